// File: rtl/dma_stride_xfer_if.sv
// dma_stride_xfer_if: descriptor, status, external-memory and RAM buses of the strided DMA.
interface dma_stride_xfer_if #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int RAW = 16,
    parameter int CW  = 11,
    parameter int SW  = 24
);
    logic           start;
    logic           dir;
    logic           abort;
    logic [AW-1:0]  base_ext;
    logic [RAW-1:0] base_ram;
    logic [CW-1:0]  len_x;
    logic [CW-1:0]  len_y;
    logic [CW-1:0]  len_z;
    logic [SW-1:0]  stride_y;
    logic [SW-1:0]  stride_z;
    logic           busy;
    logic           done;
    logic           ext_req;
    logic           ext_we;
    logic [AW-1:0]  ext_addr;
    logic [DW-1:0]  ext_wdata;
    logic           ext_rvalid;
    logic [DW-1:0]  ext_rdata;
    logic           ext_wack;
    logic           ram_we;
    logic [RAW-1:0] ram_addr;
    logic [DW-1:0]  ram_wdata;
    logic [DW-1:0]  ram_rdata;

    modport master (
        input  start, dir, abort, base_ext, base_ram, len_x, len_y, len_z, stride_y, stride_z,
        input  ext_rvalid, ext_rdata, ext_wack, ram_rdata,
        output busy, done, ext_req, ext_we, ext_addr, ext_wdata, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output start, dir, abort, base_ext, base_ram, len_x, len_y, len_z, stride_y, stride_z,
        output ext_rvalid, ext_rdata, ext_wack, ram_rdata,
        input  busy, done, ext_req, ext_we, ext_addr, ext_wdata, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dma_stride_xfer.sv
// dma_stride_xfer: bidirectional 3-D strided DMA between external memory and a linear on-chip RAM.
module dma_stride_xfer #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int RAW = 16,
    parameter int CW  = 11,
    parameter int SW  = 24
) (
    input logic             clk,
    input logic             rst,
    dma_stride_xfer_if.master bus
);
    typedef enum logic [2:0] {IDLE, EXT_RD, RAM_WR, RAM_RD, RAM_WAIT, EXT_WR, DONE} state_t;

    state_t         state_q, state_d;
    logic           dir_q, dir_d;
    logic [CW-1:0]  lx_q, lx_d, ly_q, ly_d, lz_q, lz_d;
    logic [CW-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [SW-1:0]  sy_q, sy_d, sz_q, sz_d;
    logic [AW-1:0]  row_q, row_d, plane_q, plane_d;
    logic [RAW-1:0] ram_q, ram_d;
    logic [DW-1:0]  data_q, data_d;
    logic           step, fin;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lx_d    = lx_q;
        ly_d    = ly_q;
        lz_d    = lz_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        sy_d    = sy_q;
        sz_d    = sz_q;
        row_d   = row_q;
        plane_d = plane_q;
        ram_d   = ram_q;
        data_d  = data_q;
        fin     = 1'b0;
        step    = (state_q == RAM_WR) || (state_q == EXT_WR && bus.ext_wack);
        case (state_q)
            IDLE: if (bus.start && !bus.abort) begin
                dir_d   = bus.dir;
                lx_d    = bus.len_x;
                ly_d    = bus.len_y;
                lz_d    = bus.len_z;
                sy_d    = bus.stride_y;
                sz_d    = bus.stride_z;
                x_d     = '0;
                y_d     = '0;
                z_d     = '0;
                row_d   = bus.base_ext;
                plane_d = bus.base_ext;
                ram_d   = bus.base_ram;
                state_d = (bus.len_x == '0 || bus.len_y == '0 || bus.len_z == '0) ? DONE :
                          bus.dir ? RAM_RD : EXT_RD;
            end
            EXT_RD: if (bus.ext_rvalid) begin
                data_d  = bus.ext_rdata;
                state_d = RAM_WR;
            end
            RAM_RD:   state_d = RAM_WAIT;
            RAM_WAIT: begin
                data_d  = bus.ram_rdata;
                state_d = EXT_WR;
            end
            DONE:     state_d = IDLE;
            default:  ;
        endcase
        // advance the x/y/z nest in the same cycle the word completes
        if (step) begin
            ram_d = ram_q + RAW'(1);
            if (x_q != lx_q - CW'(1)) begin
                x_d = x_q + CW'(1);
            end else begin
                x_d = '0;
                if (y_q != ly_q - CW'(1)) begin
                    y_d   = y_q + CW'(1);
                    row_d = row_q + AW'(sy_q);
                end else begin
                    y_d = '0;
                    if (z_q != lz_q - CW'(1)) begin
                        z_d     = z_q + CW'(1);
                        plane_d = plane_q + AW'(sz_q);
                        row_d   = plane_d;
                    end else begin
                        fin = 1'b1;
                    end
                end
            end
            state_d = fin ? DONE : dir_q ? RAM_RD : EXT_RD;
        end
        if (bus.abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            lx_q    <= '0;
            ly_q    <= '0;
            lz_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            sy_q    <= '0;
            sz_q    <= '0;
            row_q   <= '0;
            plane_q <= '0;
            ram_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            lx_q    <= lx_d;
            ly_q    <= ly_d;
            lz_q    <= lz_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            sy_q    <= sy_d;
            sz_q    <= sz_d;
            row_q   <= row_d;
            plane_q <= plane_d;
            ram_q   <= ram_d;
            data_q  <= data_d;
        end
    end

    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.ext_req   = (state_q == EXT_RD) || (state_q == EXT_WR);
    assign bus.ext_we    = state_q == EXT_WR;
    assign bus.ext_addr  = row_q + AW'(x_q);
    assign bus.ext_wdata = data_q;
    assign bus.ram_we    = state_q == RAM_WR;
    assign bus.ram_addr  = ram_q;
    assign bus.ram_wdata = data_q;
endmodule
